// File: rtl/l2_bank_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : l2_bank_rr_arbiter_if
// Brief    : Request/response bundle between N TCDM requesters, the arbiter
//            and a single L2 bank port.
// Revision : 1.0
// ============================================================================
interface l2_bank_rr_arbiter_if #(
    parameter int NR_MASTERS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic [NR_MASTERS-1:0]                 m_req_i;
    logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] m_add_i;
    logic [NR_MASTERS-1:0]                 m_wen_i;
    logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i;
    logic [NR_MASTERS-1:0][BE_WIDTH-1:0]   m_be_i;
    logic [NR_MASTERS-1:0]                 m_gnt_o;
    logic [NR_MASTERS-1:0]                 m_r_valid_o;
    logic [DATA_WIDTH-1:0]                 m_r_rdata_o;
    logic                                  m_r_opc_o;

    logic                                  s_req_o;
    logic [ADDR_WIDTH-1:0]                 s_add_o;
    logic                                  s_wen_o;
    logic [DATA_WIDTH-1:0]                 s_wdata_o;
    logic [BE_WIDTH-1:0]                   s_be_o;
    logic                                  s_gnt_i;
    logic                                  s_r_valid_i;
    logic [DATA_WIDTH-1:0]                 s_r_rdata_i;
    logic                                  s_r_opc_i;

    // Environment view: drives the requesters and the bank
    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
    );

    // Arbiter view
    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
    );
endinterface
`default_nettype wire

// File: rtl/l2_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_bank_rr_arbiter
// Brief    : Round-robin arbiter sharing one L2 bank among NR_MASTERS
//            requesters, with an in-order ID FIFO to route responses back.
// Revision : 1.0
// ============================================================================
module l2_bank_rr_arbiter #(
    parameter int NR_MASTERS      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_ni,
    l2_bank_rr_arbiter_if.slave bus,
    output logic                err_o
);
    localparam int c_ID_W  = $clog2(NR_MASTERS);
    localparam int c_IDX_W = c_ID_W + 1;
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [c_IDX_W-1:0] c_NR       = c_IDX_W'(NR_MASTERS);
    localparam logic [c_ID_W-1:0]  c_ID_LAST  = c_ID_W'(NR_MASTERS - 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

    logic [c_ID_W-1:0]  r_rr_ptr;
    logic [c_ID_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    logic [c_ID_W-1:0]  w_winner;
    logic [c_ID_W-1:0]  w_head;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_found;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    // Scan from r_rr_ptr upward with wrap; NR_MASTERS need not be a power of two
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
            if (w_idx >= c_NR) begin
                w_idx = w_idx - c_NR;
            end
            if (!w_found && bus.m_req_i[w_idx[c_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ID_W-1:0];
            end
        end
    end

    // Full looks at the registered count only: a pop this cycle does not free a slot yet
    assign w_full        = (r_cnt == c_FULL);
    assign bus.s_req_o   = (|bus.m_req_i) & ~w_full;
    assign bus.s_add_o   = bus.m_add_i[w_winner];
    assign bus.s_wen_o   = bus.m_wen_i[w_winner];
    assign bus.s_wdata_o = bus.m_wdata_i[w_winner];
    assign bus.s_be_o    = bus.m_be_i[w_winner];

    assign w_push = bus.s_req_o & bus.s_gnt_i;
    assign w_head = r_fifo[r_rd_ptr];
    assign w_pop  = bus.s_r_valid_i & (r_cnt != '0);

    always_comb begin
        bus.m_gnt_o           = '0;
        bus.m_gnt_o[w_winner] = w_push;
    end

    always_comb begin
        bus.m_r_valid_o         = '0;
        bus.m_r_valid_o[w_head] = w_pop;
    end

    assign bus.m_r_rdata_o = bus.s_r_rdata_i;
    assign bus.m_r_opc_o   = bus.s_r_opc_i;
    assign err_o           = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_winner;
                r_wr_ptr         <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                r_rr_ptr         <= (w_winner == c_ID_LAST) ? '0 : w_winner + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // A response with nothing outstanding is a protocol violation
            if (bus.s_r_valid_i && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_bank_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_bank_rr_arbiter
// Brief    : Scoreboard bench: 4-master/2-deep directed tests and a
//            3-master/3-deep randomised-latency run against in-order banks.
// Revision : 1.0
// ============================================================================
module tb_l2_bank_rr_arbiter;
    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    logic err_a;
    logic err_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    l2_bank_rr_arbiter_if #(.NR_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) bus_a ();
    l2_bank_rr_arbiter_if #(.NR_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)) bus_b ();

    l2_bank_rr_arbiter #(
        .NR_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_OUTSTANDING(2)
    ) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_a_n),
        .bus    (bus_a),
        .err_o  (err_a)
    );

    l2_bank_rr_arbiter #(
        .NR_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .MAX_OUTSTANDING(3)
    ) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_b_n),
        .bus    (bus_b),
        .err_o  (err_b)
    );

    typedef struct packed {
        logic [3:0]  vld;
        logic [31:0] data;
        logic        opc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bank_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  exp_a[$];
    exp_t  exp_b[$];
    bank_t bq_a[$];
    bank_t bq_b[$];
    logic  a_hold = 1'b0;
    logic  a_spur = 1'b0;
    logic  b_done = 1'b0;
    logic [3:0] wen_a = 4'b0101;

    function automatic logic [31:0] resp_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] addr_a(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] wdata_a(input int i);
        return (i == 3) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // In-order bank models: A has latency 1 (with hold/spurious controls), B latency 1..3
    initial begin : p_bank
        logic        hs_a, hs_b, hold_a, spur_a, rn_a, rn_b;
        logic [31:0] ad_a, ad_b;
        int          cyc;
        cyc = 0;
        bus_a.s_r_valid_i = 1'b0; bus_a.s_r_rdata_i = '0; bus_a.s_r_opc_i = 1'b0;
        bus_b.s_r_valid_i = 1'b0; bus_b.s_r_rdata_i = '0; bus_b.s_r_opc_i = 1'b0;
        forever begin
            @(negedge clk);
            hs_a = bus_a.s_req_o & bus_a.s_gnt_i; ad_a = bus_a.s_add_o;
            hold_a = a_hold; spur_a = a_spur; rn_a = rst_a_n;
            hs_b = bus_b.s_req_o & bus_b.s_gnt_i; ad_b = bus_b.s_add_o; rn_b = rst_b_n;
            @(posedge clk); #1;
            cyc++;
            if (!rn_a) bq_a.delete();
            else if (hs_a) bq_a.push_back('{ad_a, cyc});
            if (spur_a) begin
                bus_a.s_r_valid_i = 1'b1; bus_a.s_r_rdata_i = 32'hBAD0_0000; bus_a.s_r_opc_i = 1'b0;
            end else if (bq_a.size() > 0 && !hold_a && bq_a[0].due <= cyc) begin
                bus_a.s_r_valid_i = 1'b1;
                bus_a.s_r_rdata_i = resp_of(bq_a[0].addr);
                bus_a.s_r_opc_i   = ^bq_a[0].addr;
                void'(bq_a.pop_front());
            end else begin
                bus_a.s_r_valid_i = 1'b0; bus_a.s_r_rdata_i = '0; bus_a.s_r_opc_i = 1'b0;
            end
            if (!rn_b) bq_b.delete();
            else if (hs_b) bq_b.push_back('{ad_b, cyc + int'($urandom_range(0, 2))});
            if (bq_b.size() > 0 && bq_b[0].due <= cyc) begin
                bus_b.s_r_valid_i = 1'b1;
                bus_b.s_r_rdata_i = resp_of(bq_b[0].addr);
                bus_b.s_r_opc_i   = ^bq_b[0].addr;
                void'(bq_b.pop_front());
            end else begin
                bus_b.s_r_valid_i = 1'b0; bus_b.s_r_rdata_i = '0; bus_b.s_r_opc_i = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a DUT presents a response
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.m_r_valid_o != '0) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_rvalid", 32'(bus_a.m_r_valid_o), 32'h0);
                end else begin
                    e = exp_a.pop_front();
                    check("a_rvalid", 32'(bus_a.m_r_valid_o), 32'(e.vld));
                    check("a_rdata", bus_a.m_r_rdata_o, e.data);
                    check("a_ropc", 32'(bus_a.m_r_opc_o), 32'(e.opc));
                end
            end
            if (bus_b.m_r_valid_o != '0) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_rvalid", 32'(bus_b.m_r_valid_o), 32'h0);
                end else begin
                    e = exp_b.pop_front();
                    check("b_rvalid", 32'(bus_b.m_r_valid_o), 32'(e.vld));
                    check("b_rdata", bus_b.m_r_rdata_o, e.data);
                    check("b_ropc", 32'(bus_b.m_r_opc_o), 32'(e.opc));
                end
            end
        end
    end

    // One cycle on DUT A: drive, check grant path mid-cycle, push the expected response
    task automatic step_a(input logic [3:0] req, input logic gnt, input logic exp_sreq,
                          input logic [3:0] exp_gnt, input string tag);
        int w;
        w = -1;
        bus_a.m_req_i = req;
        bus_a.s_gnt_i = gnt;
        @(negedge clk);
        check({tag, "_sreq"}, 32'(bus_a.s_req_o), 32'(exp_sreq));
        check({tag, "_gnt"}, 32'(bus_a.m_gnt_o), 32'(exp_gnt));
        for (int i = 0; i < 4; i++) if (exp_gnt[i]) w = i;
        if (w >= 0) begin
            check({tag, "_add"}, bus_a.s_add_o, addr_a(w));
            check({tag, "_wdata"}, bus_a.s_wdata_o, wdata_a(w));
            check({tag, "_wen"}, 32'(bus_a.s_wen_o), 32'(wen_a[w]));
            exp_a.push_back('{vld: exp_gnt, data: resp_of(addr_a(w)), opc: ^addr_a(w)});
        end
        @(posedge clk); #1;
    endtask

    initial begin : p_stim_a
        rst_a_n = 1'b0;
        bus_a.m_req_i = '0; bus_a.s_gnt_i = 1'b0; bus_a.m_wen_i = wen_a;
        for (int i = 0; i < 4; i++) begin
            bus_a.m_add_i[i] = addr_a(i); bus_a.m_wdata_i[i] = wdata_a(i); bus_a.m_be_i[i] = 4'hF;
        end
        repeat (2) @(posedge clk); #1;
        // Reset: combinational request path live, responses and error quiet
        step_a(4'hF, 1'b0, 1'b1, 4'h0, "rst");
        check("rst_err", 32'(err_a), 32'h0);
        check("rst_rvalid", 32'(bus_a.m_r_valid_o), 32'h0);
        check("rst_add", bus_a.s_add_o, addr_a(0));
        rst_a_n = 1'b1;
        // Rotation 0,1,2,3,0
        step_a(4'hF, 1'b1, 1'b1, 4'b0001, "rot0");
        step_a(4'hF, 1'b1, 1'b1, 4'b0010, "rot1");
        step_a(4'hF, 1'b1, 1'b1, 4'b0100, "rot2");
        step_a(4'hF, 1'b1, 1'b1, 4'b1000, "rot3");
        step_a(4'hF, 1'b1, 1'b1, 4'b0001, "rot4");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle0");
        // Move pointer to 2, then skip idle masters 0 and 2
        step_a(4'b0010, 1'b1, 1'b1, 4'b0010, "pre_skip");
        step_a(4'b1010, 1'b1, 1'b1, 4'b1000, "skip0");
        step_a(4'b1010, 1'b1, 1'b1, 4'b0010, "skip1");
        step_a(4'b1010, 1'b1, 1'b1, 4'b1000, "skip2");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle1");
        // Bank stall keeps the pointer; original winner granted afterwards
        step_a(4'b0101, 1'b0, 1'b1, 4'b0000, "stall0");
        step_a(4'b0101, 1'b0, 1'b1, 4'b0000, "stall1");
        step_a(4'b0101, 1'b0, 1'b1, 4'b0000, "stall2");
        step_a(4'b0101, 1'b1, 1'b1, 4'b0001, "stall_go");
        step_a(4'b0101, 1'b1, 1'b1, 4'b0100, "stall_next");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle2");
        // Full: two outstanding, pop cycle still blocked, re-issue the cycle after
        a_hold = 1'b1;
        step_a(4'hF, 1'b1, 1'b1, 4'b1000, "full0");
        step_a(4'hF, 1'b1, 1'b1, 4'b0001, "full1");
        step_a(4'hF, 1'b1, 1'b0, 4'b0000, "full2");
        a_hold = 1'b0;
        step_a(4'hF, 1'b1, 1'b0, 4'b0000, "full3");
        step_a(4'hF, 1'b1, 1'b0, 4'b0000, "full_pop");
        step_a(4'hF, 1'b1, 1'b1, 4'b0010, "full_re");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle3");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle4");
        // Reset with two outstanding, then a spurious response
        a_hold = 1'b1;
        step_a(4'hF, 1'b1, 1'b1, 4'b0100, "rm0");
        step_a(4'hF, 1'b1, 1'b1, 4'b1000, "rm1");
        rst_a_n = 1'b0;
        exp_a.delete();
        step_a(4'h0, 1'b0, 1'b0, 4'b0000, "rm_rst");
        check("rm_err", 32'(err_a), 32'h0);
        rst_a_n = 1'b1;
        a_hold  = 1'b0;
        step_a(4'h0, 1'b0, 1'b0, 4'b0000, "rm_rel");
        a_spur = 1'b1;
        step_a(4'h0, 1'b0, 1'b0, 4'b0000, "sp_arm");
        a_spur = 1'b0;
        @(negedge clk);
        check("sp_rvalid", 32'(bus_a.m_r_valid_o), 32'h0);
        check("sp_err_before", 32'(err_a), 32'h0);
        @(posedge clk); #1;
        check("sp_err_after", 32'(err_a), 32'h1);
        step_a(4'hF, 1'b1, 1'b1, 4'b0001, "sp_t0");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle5");
        step_a(4'h0, 1'b1, 1'b0, 4'b0000, "idle6");
        check("sp_err_sticky", 32'(err_a), 32'h1);
        rst_a_n = 1'b0;
        #1;
        check("sp_err_cleared", 32'(err_a), 32'h0);
        @(posedge clk); #1;
        rst_a_n = 1'b1;

        for (int t = 0; t < 20000 && !b_done; t++) @(posedge clk);
        check("b_finished", 32'(b_done), 32'h1);
        check("a_scoreboard_empty", 32'(exp_a.size()), 32'h0);
        check("b_scoreboard_empty", 32'(exp_b.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // DUT B: all three masters always requesting, bank grants randomly
    initial begin : p_stim_b
        int         mcnt, rr, issued;
        int         seq[3];
        logic       hs, esreq;
        logic [3:0] eg;
        logic [31:0] ad;
        rst_b_n = 1'b0;
        bus_b.m_req_i = '0; bus_b.s_gnt_i = 1'b0; bus_b.m_wen_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            seq[i] = 0; bus_b.m_add_i[i] = '0; bus_b.m_wdata_i[i] = '0; bus_b.m_be_i[i] = 4'hF;
        end
        repeat (3) @(posedge clk); #1;
        rst_b_n = 1'b1;
        mcnt = 0; rr = 0; issued = 0;
        for (int cyc = 0; cyc < 5000 && issued < 1000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                bus_b.m_add_i[i]   = (32'(i) << 24) | 32'(seq[i]);
                bus_b.m_wdata_i[i] = 32'(seq[i]);
            end
            bus_b.m_req_i = 3'b111;
            bus_b.s_gnt_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            esreq = (mcnt < 3);
            hs    = esreq & bus_b.s_gnt_i;
            eg    = hs ? (4'b0001 << rr) : 4'b0000;
            check("b_sreq", 32'(bus_b.s_req_o), 32'(esreq));
            check("b_gnt", 32'(bus_b.m_gnt_o), 32'(eg));
            if (bus_b.s_r_valid_i && mcnt > 0) mcnt--;
            if (hs) begin
                ad = (32'(rr) << 24) | 32'(seq[rr]);
                exp_b.push_back('{vld: eg, data: resp_of(ad), opc: ^ad});
                seq[rr]++;
                rr = (rr + 1) % 3;
                issued++;
                mcnt++;
            end
            @(posedge clk); #1;
        end
        bus_b.m_req_i = '0;
        repeat (10) @(posedge clk);
        #1;
        check("b_err", 32'(err_b), 32'h0);
        b_done = 1'b1;
    end
endmodule
`default_nettype wire

// File: doc/l2_bank_rr_arbiter.md
# l2_bank_rr_arbiter

Round-robin arbiter that lets NR_MASTERS TCDM-style requesters share one L2 bank (slave) port. It keeps an in-order table of outstanding transaction IDs so each bank response returns to the master that issued it. It sits between an interleaved crossbar's slave-side outputs and a single-ported memory bank, wherever several requesters contend for the same bank.

## Interface
Parameters:
- NR_MASTERS, 4: number of requesters; ≥2, not required to be a power of two.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width.
- MAX_OUTSTANDING, 2: depth of the ID FIFO; ≥1.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- m_req_i  in  NR_MASTERS  per-master request.
- m_add_i  in  NR_MASTERS×ADDR_WIDTH  per-master address.
- m_wen_i  in  NR_MASTERS  per-master write enable; 1 = read, 0 = write (TCDM convention).
- m_wdata_i  in  NR_MASTERS×DATA_WIDTH  per-master write data.
- m_be_i  in  NR_MASTERS×BE_WIDTH  per-master byte enables.
- m_gnt_o  out  NR_MASTERS  one-hot grant.
- m_r_valid_o  out  NR_MASTERS  one-hot response valid.
- m_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters.
- m_r_opc_o  out  1  response error/opcode, broadcast.
- s_req_o  out  1  bank request.
- s_add_o, s_wen_o, s_wdata_o, s_be_o  out  as master side  fields of the muxed winner.
- s_gnt_i  in  1  bank grant.
- s_r_valid_i  in  1  bank response; responses arrive in issue order, one per granted request (reads and writes).
- s_r_rdata_i  in  DATA_WIDTH; s_r_opc_i  in  1  bank response payload.
- err_o  out  1  sticky protocol error flag.

## Operation
- State:
  - rr_ptr: index of the highest-priority master, range 0..NR_MASTERS-1.
  - ID FIFO: MAX_OUTSTANDING entries, each $clog2(NR_MASTERS) bits wide.
  - cnt: occupancy, $clog2(MAX_OUTSTANDING+1) bits.
  - err_q: sticky error bit.
- full = (cnt == MAX_OUTSTANDING). It is evaluated on registered cnt only, so a same-cycle pop does NOT unblock issue.
- Arbitration is combinational:
  - winner = first i with m_req_i[i]=1, scanning rr_ptr, rr_ptr+1, … with wrap modulo NR_MASTERS.
  - s_req_o = (|m_req_i) & ~full.
  - s_add_o, s_wen_o, s_wdata_o, s_be_o carry the winner's fields. When s_req_o=0 they are don't-care, but must not be X in simulation.
  - m_gnt_o[winner] = s_gnt_i & s_req_o; all other grant bits are 0.
- Handshake (s_req_o & s_gnt_i) at a clock edge:
  - push winner ID into the FIFO;
  - rr_ptr ← (winner+1) mod NR_MASTERS.
  - rr_ptr is unchanged when no handshake occurs, including when the bank stalls with s_gnt_i=0.
- Response:
  - If s_r_valid_i=1 and cnt>0: m_r_valid_o[head ID]=1, then pop at the edge.
  - m_r_rdata_o = s_r_rdata_i and m_r_opc_o = s_r_opc_i, passed through unconditionally.
- Same-cycle push and pop: cnt is unchanged, the head advances and the new entry is written at the tail.
- Spurious response (s_r_valid_i=1 while cnt==0): no m_r_valid_o bit asserts, no pop, err_q ← 1.
- err_o = err_q. It is cleared only by reset.
- A master may drop m_req_i before it is granted; the arbiter keeps no history of ungranted requests.

## Timing
- Grant: 0-cycle combinational path m_req_i → s_req_o and s_gnt_i → m_gnt_o.
- Response: 0-cycle combinational path s_r_valid_i → m_r_valid_o. The arbiter adds no latency, so end-to-end latency equals the bank latency.
- Throughput: one request per cycle while cnt < MAX_OUTSTANDING. With MAX_OUTSTANDING=1 and bank latency 1, issue alternates every other cycle (full blocks on the pop cycle).
- Reset, asynchronous assertion:
  - rr_ptr=0, cnt=0, FIFO pointers 0, err_q=0.
  - Outputs during and after reset: err_o=0, m_r_valid_o=0. s_req_o, m_gnt_o and the s_* fields follow the combinational rules with cnt=0.
- Reset mid-operation: outstanding IDs are discarded. Any later bank response arriving with cnt==0 sets err_o.
- FIFO read and write pointers wrap modulo MAX_OUTSTANDING, which need not be a power of two.

## Test plan
- Rotation: all 4 masters hold req, s_gnt_i=1, bank latency 1, MAX_OUTSTANDING=2 → grants go 0,1,2,3,0 on consecutive cycles, and each m_r_valid_o pulse goes to the ID granted one cycle earlier.
- Skip idle: only masters 1 and 3 request, rr_ptr=2 → master 3 granted, then 1, then 3. Master 3's write data 0xDEADBEEF appears on s_wdata_o in its grant cycle.
- Bank stall: s_gnt_i=0 for 3 cycles with masters 0 and 2 requesting → m_gnt_o=0 throughout and rr_ptr stays put. When s_gnt_i rises, the original winner is granted.
- Full: MAX_OUTSTANDING=2, 2 grants issued, bank withholds s_r_valid_i → s_req_o=0. On the pop cycle s_req_o is still 0; the next cycle it re-asserts.
- Spurious/reset: assert rst_ni=0 with 2 outstanding, release, then drive s_r_valid_i=1 → m_r_valid_o=0 and err_o=1 from the next edge; it stays 1 until the next reset.
- Odd count: NR_MASTERS=3, MAX_OUTSTANDING=3, all requesting, random bank latency 1–3 cycles, in order → every response reaches the correct master and err_o remains 0 over 1000 transactions.
